// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: CDB broadcast, ROB entry and the ROB tag width.
// Pure type/constant package, no logic, no latency, no flow control.
package lc3b_types;

   localparam int rob_tag_width = 3;

   typedef logic [15:0]              lc3b_word;
   typedef logic [2:0]               lc3b_reg;
   typedef logic [rob_tag_width-1:0] rob_tag_t;

   typedef struct packed {
      logic     valid;
      rob_tag_t tag;
      lc3b_word data;
   } cdb_t;

   typedef struct packed {
      logic     busy;
      logic     ready;
      logic     regwrite;
      lc3b_reg  dest;
      lc3b_word data;
   } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB storage with per-entry CDB tag compare; alloc/capture/retire take effect at the edge.
// No backpressure: the parent guarantees alloc targets a free entry and retire a busy one.
module rob_entry_array
   import lc3b_types::*;
#(
   parameter int n = rob_tag_width
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      alloc_en,
   input  logic [n-1:0]              alloc_idx,
   input  logic                      alloc_regwrite,
   input  logic [2:0]                alloc_dest,
   input  cdb_t                      cdb,
   input  logic                      commit_en,
   input  logic [n-1:0]              commit_idx,
   output rob_entry_t [2**n-1:0]     entries
);

   localparam int depth = 2**n;

   for (genvar g = 0; g < depth; g++) begin : g_entry
      localparam logic [n-1:0] idx = n'(g);

      rob_entry_t ent;
      logic       hit;

      // A result for an entry that is not in flight is stale and must not land.
      assign hit = cdb.valid && (cdb.tag == idx) && ent.busy;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            ent.busy  <= 1'b0;
            ent.ready <= 1'b0;
         end else if (alloc_en && (alloc_idx == idx)) begin
            ent.busy     <= 1'b1;
            ent.ready    <= 1'b0;
            ent.regwrite <= alloc_regwrite;
            ent.dest     <= alloc_dest;
         end else begin
            if (hit) begin
               ent.ready <= 1'b1;
               ent.data  <= cdb.data;
            end
            if (commit_en && (commit_idx == idx)) begin
               ent.busy <= 1'b0;
            end
         end
      end

      assign entries[g] = ent;
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular ROB: tag = tail at alloc (0 cycles), CDB captured at the edge, in-order commit from registered state.
// Alloc while full is dropped; optional operand read ports with CDB forwarding under ROB_OPERAND_READ_EN.
module reorder_buffer
   import lc3b_types::*;
#(
   parameter int n = rob_tag_width
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           alloc,
   input  logic           alloc_regwrite,
   input  logic [2:0]     alloc_dest,
   output logic [n-1:0]   alloc_tag,
   output logic           rob_full,
   output logic           rob_empty,
   input  cdb_t           CDB_in,
   output logic           commit_valid,
   output logic [n-1:0]   commit_tag,
   output logic           commit_regwrite,
   output logic [2:0]     commit_dest,
   output logic [15:0]    commit_data
`ifdef ROB_OPERAND_READ_EN
   ,
   input  logic [n-1:0]   query_tag_a,
   input  logic [n-1:0]   query_tag_b,
   output logic           query_ready_a,
   output logic           query_ready_b,
   output logic [15:0]    query_data_a,
   output logic [15:0]    query_data_b
`endif
);

   localparam int depth = 2**n;

   logic [n-1:0]          head;
   logic [n-1:0]          tail;
   logic [n:0]            count;
   logic                  do_alloc;
   rob_entry_t            head_e;
   rob_entry_t [depth-1:0] entries;

   assign rob_full  = (count == (n+1)'(depth));
   assign rob_empty = (count == '0);
   assign alloc_tag = tail;

   // Full is judged before this cycle's commit, so a same-cycle retire never frees a slot early.
   assign do_alloc = alloc && !rob_full;

   assign head_e          = entries[head];
   assign commit_valid    = head_e.busy && head_e.ready && !flush;
   assign commit_tag      = head;
   assign commit_regwrite = head_e.regwrite;
   assign commit_dest     = head_e.dest;
   assign commit_data     = head_e.data;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_alloc) begin
            tail <= tail + 1'b1;
         end
         if (commit_valid) begin
            head <= head + 1'b1;
         end
         case ({do_alloc, commit_valid})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   rob_entry_array #(.n(n)) u_entries (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .alloc_en       (do_alloc),
      .alloc_idx      (tail),
      .alloc_regwrite (alloc_regwrite),
      .alloc_dest     (alloc_dest),
      .cdb            (CDB_in),
      .commit_en      (commit_valid),
      .commit_idx     (head),
      .entries        (entries)
   );

`ifdef ROB_OPERAND_READ_EN
   rob_entry_t qa_e;
   rob_entry_t qb_e;
   logic       qa_fwd;
   logic       qb_fwd;

   assign qa_e = entries[query_tag_a];
   assign qb_e = entries[query_tag_b];

   // Same-cycle bypass: a result on the CDB is visible to readers before it is written.
   assign qa_fwd = CDB_in.valid && (CDB_in.tag == query_tag_a) && qa_e.busy;
   assign qb_fwd = CDB_in.valid && (CDB_in.tag == query_tag_b) && qb_e.busy;

   assign query_ready_a = (qa_e.busy && qa_e.ready) || qa_fwd;
   assign query_ready_b = (qb_e.busy && qb_e.ready) || qb_fwd;
   assign query_data_a  = qa_fwd ? CDB_in.data : qa_e.data;
   assign query_data_b  = qb_fwd ? CDB_in.data : qb_e.data;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: reset table, directed corner sequences, random traffic vs a queue model.
`timescale 1ns/1ps
module tb_reorder_buffer;
   import lc3b_types::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset, flush, alloc, alloc_regwrite;
   logic [2:0]  alloc_dest;
   logic [2:0]  alloc_tag;
   logic        rob_full, rob_empty;
   cdb_t        cdb_in;
   logic        commit_valid;
   logic [2:0]  commit_tag;
   logic        commit_regwrite;
   logic [2:0]  commit_dest;
   logic [15:0] commit_data;
`ifdef ROB_OPERAND_READ_EN
   logic [2:0]  query_tag_a, query_tag_b;
   logic        query_ready_a, query_ready_b;
   logic [15:0] query_data_a, query_data_b;
`endif

   always #5 clk = ~clk;

   reorder_buffer #(.n(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .alloc           (alloc),
      .alloc_regwrite  (alloc_regwrite),
      .alloc_dest      (alloc_dest),
      .alloc_tag       (alloc_tag),
      .rob_full        (rob_full),
      .rob_empty       (rob_empty),
      .CDB_in          (cdb_in),
      .commit_valid    (commit_valid),
      .commit_tag      (commit_tag),
      .commit_regwrite (commit_regwrite),
      .commit_dest     (commit_dest),
      .commit_data     (commit_data)
`ifdef ROB_OPERAND_READ_EN
      ,
      .query_tag_a     (query_tag_a),
      .query_tag_b     (query_tag_b),
      .query_ready_a   (query_ready_a),
      .query_ready_b   (query_ready_b),
      .query_data_a    (query_data_a),
      .query_data_b    (query_data_b)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: program-order queue of in-flight tags plus per-tag result state.
   int          m_order[$];
   bit          m_ready[DEPTH];
   logic [15:0] m_data[DEPTH];
   bit          m_rw[DEPTH];
   logic [2:0]  m_dest[DEPTH];
   int          m_head, m_tail;

   int          commits[$];
   logic [15:0] commit_vals[$];
   int          q_a = 0, q_b = 0;
   logic [31:0] s_tag, s_full, s_empty, s_cv, s_ctag, s_cdata, s_qra, s_qda;

   typedef struct {
      int al, cv, ct, cd, fl;
      int e_tag, e_full, e_empty, e_cv, e_ctag, e_cdata;
   } vec_t;
   vec_t tbl[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int t);
      foreach (m_order[i]) if (m_order[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      m_order.delete();
      m_head = 0;
      m_tail = 0;
      for (int i = 0; i < DEPTH; i++) m_ready[i] = 1'b0;
   endtask

   task automatic check_query(input string nm, input int q, input logic rdy, input logic [15:0] dat,
                              input bit cv, input int ct, input logic [15:0] cd);
      bit b, fwd, e_r;
      b   = m_busy(q);
      fwd = cv && (ct == q) && b;
      e_r = (b && m_ready[q]) || fwd;
      check({nm, "_ready"}, 32'(rdy), 32'(e_r));
      if (e_r) check({nm, "_data"}, 32'(dat), fwd ? 32'(cd) : 32'(m_data[q]));
   endtask

   // Called at posedge+1; drives one cycle, checks against the model, then advances the model.
   task automatic step(input bit al, input bit rw, input logic [2:0] d,
                       input bit cv, input int ct, input logic [15:0] cd, input bit fl);
      bit e_cv, was_full;
      alloc = al; alloc_regwrite = rw; alloc_dest = d;
      cdb_in.valid = cv; cdb_in.tag = 3'(ct); cdb_in.data = cd; flush = fl;
`ifdef ROB_OPERAND_READ_EN
      query_tag_a = 3'(q_a); query_tag_b = 3'(q_b);
`endif
      #1;
      was_full = (m_order.size() == DEPTH);
      e_cv = (m_order.size() > 0) && !fl;
      if (e_cv) e_cv = m_ready[m_order[0]];
      s_tag = 32'(alloc_tag); s_full = 32'(rob_full); s_empty = 32'(rob_empty);
      s_cv = 32'(commit_valid); s_ctag = 32'(commit_tag); s_cdata = 32'(commit_data);
      check("rob_full", s_full, 32'(was_full));
      check("rob_empty", s_empty, 32'(m_order.size() == 0));
      check("alloc_tag", s_tag, 32'(m_tail));
      check("commit_valid", s_cv, 32'(e_cv));
      check("commit_tag", s_ctag, 32'(m_head));
      if (e_cv) begin
         check("commit_data", s_cdata, 32'(m_data[m_head]));
         check("commit_regwrite", 32'(commit_regwrite), 32'(m_rw[m_head]));
         check("commit_dest", 32'(commit_dest), 32'(m_dest[m_head]));
      end
      if (commit_valid) begin
         commits.push_back(int'(commit_tag));
         commit_vals.push_back(commit_data);
      end
`ifdef ROB_OPERAND_READ_EN
      s_qra = 32'(query_ready_a); s_qda = 32'(query_data_a);
      check_query("query_a", q_a, query_ready_a, query_data_a, cv, ct, cd);
      check_query("query_b", q_b, query_ready_b, query_data_b, cv, ct, cd);
`endif
      @(posedge clk);
      if (fl) begin
         m_clear();
      end else begin
         if (cv && m_busy(ct)) begin
            m_ready[ct] = 1'b1;
            m_data[ct]  = cd;
         end
         if (e_cv) begin
            void'(m_order.pop_front());
            m_head = (m_head + 1) % DEPTH;
         end
         if (al && !was_full) begin
            m_order.push_back(m_tail);
            m_ready[m_tail] = 1'b0;
            m_rw[m_tail]    = rw;
            m_dest[m_tail]  = d;
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 3'd0, 1'b0, 0, 16'h0, 1'b0);
   endtask

   task automatic drain(input int max_cycles);
      int k;
      k = 0;
      while (m_order.size() > 0 && k < max_cycles) begin
         idle();
         k++;
      end
      check("drain_empty", 32'(rob_empty), 32'd1);
   endtask

   task automatic check_log(input string nm, input int exp_tags[8], input int len);
      check({nm, "_count"}, 32'(commits.size()), 32'(len));
      for (int i = 0; i < len; i++) begin
         check({nm, "_tag"}, (i < commits.size()) ? 32'(commits[i]) : 32'hFFFF_FFFF, 32'(exp_tags[i]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_seq[8];
      int ct;

      // reset
      reset = 1'b1; flush = 1'b0; alloc = 1'b0; alloc_regwrite = 1'b0; alloc_dest = 3'd0;
      cdb_in = '0;
`ifdef ROB_OPERAND_READ_EN
      query_tag_a = 3'd0; query_tag_b = 3'd0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_clear();
      check("reset_full", 32'(rob_full), 32'd0);
      check("reset_empty", 32'(rob_empty), 32'd1);
      check("reset_alloc_tag", 32'(alloc_tag), 32'd0);
      check("reset_commit_valid", 32'(commit_valid), 32'd0);
      check("reset_commit_tag", 32'(commit_tag), 32'd0);
`ifdef ROB_OPERAND_READ_EN
      check("reset_query_a", 32'(query_ready_a), 32'd0);
`endif

      // fill, overfill, commit-while-full, flush with ready head
      tbl[0] = '{1,0,0,0,0,      0,0,1,0,0,0};
      for (int i = 1; i < 8; i++) tbl[i] = '{1,0,0,0,0, i,0,0,0,0,0};
      tbl[8]  = '{1,0,0,0,0,      0,1,0,0,0,0};
      tbl[9]  = '{0,1,5,'h0055,0, 0,1,0,0,0,0};
      tbl[10] = '{0,1,0,'h1234,0, 0,1,0,0,0,0};
      tbl[11] = '{1,0,0,0,0,      0,1,0,1,0,'h1234};
      tbl[12] = '{0,0,0,0,0,      0,0,0,0,1,0};
      tbl[13] = '{1,0,0,0,0,      0,0,0,0,1,0};
      tbl[14] = '{0,1,1,'h0011,0, 1,1,0,0,1,0};
      tbl[15] = '{0,1,2,'h0022,1, 1,1,0,0,1,0};
      tbl[16] = '{0,0,0,0,0,      0,0,1,0,0,0};
      for (int i = 0; i < 17; i++) begin
         step(1'(tbl[i].al), 1'(i % 2), 3'(i), 1'(tbl[i].cv), tbl[i].ct, 16'(tbl[i].cd), 1'(tbl[i].fl));
         check("tbl_alloc_tag", s_tag, 32'(tbl[i].e_tag));
         check("tbl_full", s_full, 32'(tbl[i].e_full));
         check("tbl_empty", s_empty, 32'(tbl[i].e_empty));
         check("tbl_commit_valid", s_cv, 32'(tbl[i].e_cv));
         check("tbl_commit_tag", s_ctag, 32'(tbl[i].e_ctag));
         if (tbl[i].e_cv != 0) check("tbl_commit_data", s_cdata, 32'(tbl[i].e_cdata));
      end

      // out-of-order results, in-order commits
      commits.delete(); commit_vals.delete();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'(i + 3), 1'b0, 0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b1, 2, 16'h0002, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b1, 0, 16'h0000, 1'b0);
      check("no_early_commit", 32'(commits.size()), 32'd0);
      step(1'b0, 1'b0, 3'd0, 1'b1, 1, 16'h0001, 1'b0);
      drain(10);
      exp_seq = '{0,1,2,0,0,0,0,0};
      check_log("inorder", exp_seq, 3);
      for (int i = 0; i < 3 && i < commit_vals.size(); i++)
         check("inorder_data", 32'(commit_vals[i]), 32'(i));

      // result to a non-busy tag must not leak into a later allocation
      step(1'b0, 1'b0, 3'd0, 1'b1, 5, 16'hBEEF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 3'd1, 1'b0, 0, 16'h0, 1'b0);
         check("stale_alloc_tag", s_tag, 32'(i + 3));
      end
      step(1'b0, 1'b0, 3'd0, 1'b1, 3, 16'h0333, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b1, 4, 16'h0444, 1'b0);
      idle();
      q_a = 5;
      idle();
      check("stale_no_commit", s_cv, 32'd0);
      check("stale_not_empty", s_empty, 32'd0);
      check("stale_head", s_ctag, 32'd5);
`ifdef ROB_OPERAND_READ_EN
      check("stale_query_ready", s_qra, 32'd0);
`endif
      q_a = 0;
      step(1'b0, 1'b0, 3'd0, 1'b1, 5, 16'h5555, 1'b0);
      idle();
      check("stale_commit_valid", s_cv, 32'd1);
      check("stale_commit_data", s_cdata, 32'h5555);

      // wraparound: fill, retire three, reissue tags 0..2
      step(1'b0, 1'b0, 3'd0, 1'b0, 0, 16'h0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 1'b0, 0, 16'h0, 1'b0);
      commits.delete(); commit_vals.delete();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 1'b1, i, 16'(i * 257), 1'b0);
      idle();
      check("wrap_first_commits", 32'(commits.size()), 32'd3);
      commits.delete(); commit_vals.delete();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 3'(7 - i), 1'b0, 0, 16'h0, 1'b0);
         check("wrap_reissue_tag", s_tag, 32'(i));
      end
      exp_seq = '{7,5,3,6,4,1,0,2};
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b1, exp_seq[i], 16'(exp_seq[i] * 257), 1'b0);
      drain(20);
      exp_seq = '{3,4,5,6,7,0,1,2};
      check_log("wrap", exp_seq, 8);

      // flush with busy entries and a concurrent CDB
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i), 1'b0, 0, 16'h0, 1'b0);
      commits.delete(); commit_vals.delete();
      q_a = 4;
      step(1'b0, 1'b0, 3'd0, 1'b1, 4, 16'hABCD, 1'b0);
`ifdef ROB_OPERAND_READ_EN
      check("fwd_query_ready", s_qra, 32'd1);
      check("fwd_query_data", s_qda, 32'hABCD);
`endif
      q_a = 0;
      step(1'b0, 1'b0, 3'd0, 1'b1, 3, 16'h0333, 1'b0);
      step(1'b1, 1'b0, 3'd0, 1'b1, 5, 16'h0555, 1'b1);
      check("flush_commit_valid", s_cv, 32'd0);
      idle();
      check("flush_empty", s_empty, 32'd1);
      check("flush_alloc_tag", s_tag, 32'd0);
      check("flush_no_commits", 32'(commits.size()), 32'd0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         q_a = int'($urandom_range(0, 7));
         q_b = int'($urandom_range(0, 7));
         if (m_order.size() > 0 && ($urandom % 4) != 0)
            ct = m_order[$urandom_range(0, m_order.size() - 1)];
         else
            ct = int'($urandom_range(0, 7));
         step(1'(($urandom % 3) != 0), 1'($urandom), 3'($urandom), 1'(($urandom % 4) != 0),
              ct, 16'($urandom), 1'(($urandom % 64) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
